// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundles the MEM-stage, bridge and data-memory signals
// around the dm arbiter. The slave modport is the arbiter's view and the
// master modport is the view of everything connected to it.
interface dm_arbiter_if;
  // MEM stage (requester M)
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wd;
  logic [31:0] m_pc;
  logic        m_stall;
  logic [31:0] m_rdata;
  logic        m_rvalid;

  // Bridge/debug port (requester B)
  logic        b_valid;
  logic        b_ready;
  logic        b_we;
  logic [31:0] b_addr;
  logic [31:0] b_wd;
  logic        b_rvalid;
  logic [31:0] b_rdata;

  // Data memory side
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [31:0] dm_pc;
  logic [31:0] dm_rd;

  modport slave (
    input  m_req, m_we, m_addr, m_wd, m_pc,
    output m_stall, m_rdata, m_rvalid,
    input  b_valid, b_we, b_addr, b_wd,
    output b_ready, b_rvalid, b_rdata,
    output dm_we, dm_addr, dm_wd, dm_pc,
    input  dm_rd
  );

  modport master (
    output m_req, m_we, m_addr, m_wd, m_pc,
    input  m_stall, m_rdata, m_rvalid,
    output b_valid, b_we, b_addr, b_wd,
    input  b_ready, b_rvalid, b_rdata,
    input  dm_we, dm_addr, dm_wd, dm_pc,
    output dm_rd
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the MEM stage (M)
// and the bridge port (B). One access per cycle, reads take one extra cycle
// to return, M is stalled while it waits, and B gets priority once it has
// been denied B_MAX_WAIT cycles in a row.
module dm_arbiter #(
  parameter int B_MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           reset,
  dm_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_M = 2'd1,
    RD_B = 2'd2
  } state_t;

  localparam logic [3:0]  B_WAIT_MAX = 4'(B_MAX_WAIT);
  localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

  state_t     r_state;
  logic [3:0] r_bWait;

  logic w_grantM;
  logic w_grantB;

  // Arbitration: grants are only possible in IDLE; B wins a tie only once
  // its wait counter has saturated.
  always_comb begin
    w_grantM = 1'b0;
    w_grantB = 1'b0;
    if (r_state == IDLE) begin
      if (bus.m_req && bus.b_valid) begin
        if (r_bWait == B_WAIT_MAX) begin
          w_grantB = 1'b1;
        end else begin
          w_grantM = 1'b1;
        end
      end else if (bus.m_req) begin
        w_grantM = 1'b1;
      end else if (bus.b_valid) begin
        w_grantB = 1'b1;
      end
    end
  end

  // Output decode from state and inputs; reset forces every output low at
  // once, without waiting for a clock edge.
  always_comb begin
    bus.m_stall  = 1'b0;
    bus.m_rdata  = 32'h0;
    bus.m_rvalid = 1'b0;
    bus.b_ready  = 1'b0;
    bus.b_rvalid = 1'b0;
    bus.b_rdata  = 32'h0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h0;
    bus.dm_wd    = 32'h0;
    bus.dm_pc    = 32'h0;
    if (reset) begin
      case (r_state)
        IDLE: begin
          if (w_grantM) begin
            bus.dm_we   = bus.m_we;
            bus.dm_addr = bus.m_addr & WORD_MASK;
            bus.dm_wd   = bus.m_we ? bus.m_wd : 32'h0;
            bus.dm_pc   = bus.m_pc;
            bus.m_stall = ~bus.m_we;
          end else if (w_grantB) begin
            bus.b_ready = 1'b1;
            bus.dm_we   = bus.b_we;
            bus.dm_addr = bus.b_addr & WORD_MASK;
            bus.dm_wd   = bus.b_we ? bus.b_wd : 32'h0;
            bus.m_stall = bus.m_req;
          end
        end
        RD_M: begin
          bus.m_rvalid = 1'b1;
          bus.m_rdata  = bus.dm_rd;
        end
        RD_B: begin
          bus.b_rvalid = 1'b1;
          bus.b_rdata  = bus.dm_rd;
          bus.m_stall  = bus.m_req;
        end
        default: begin
          bus.m_stall = 1'b0;
        end
      endcase
    end
  end

  // Sequencer and B starvation counter: reads park in RD_M/RD_B for the
  // one-cycle memory latency; the counter tracks consecutive denied cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_bWait <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grantM && !bus.m_we) begin
            r_state <= RD_M;
          end else if (w_grantB && !bus.b_we) begin
            r_state <= RD_B;
          end else begin
            r_state <= IDLE;
          end
        end
        RD_M:    r_state <= IDLE;
        RD_B:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (bus.b_valid && !w_grantB) begin
        if (r_bWait != B_WAIT_MAX) begin
          r_bWait <= r_bWait + 4'd1;
        end
      end else begin
        r_bWait <= 4'd0;
      end
    end
  end

endmodule
